// File: rtl/route_table_writer.sv
// rtl/route_table_writer.sv - add/delete command engine writing the lookup CAM and port RAM
// Keeps a shadow {valid, key, port} table to find duplicates, free slots and missing keys.
module route_table_writer #(
    parameter int DEPTH = 4,
    parameter int KEY_W = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk50Mhz,
    input  logic             reset,
    input  logic             i_wr_req,
    input  logic             i_del_req,
    input  logic [KEY_W-1:0] i_key,
    input  logic             i_port_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_status,
    output logic             o_cam_we,
    output logic [IDX_W-1:0] o_cam_index,
    output logic [KEY_W-1:0] o_cam_key,
    output logic             o_cam_valid,
    output logic             o_ram_we,
    output logic [IDX_W-1:0] o_ram_addr,
    output logic             o_ram_data,
    output logic [IDX_W:0]   o_entry_count
);

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_WRITE, S_DONE} state_t;

    localparam logic [1:0]     ST_ADDED   = 2'b00;
    localparam logic [1:0]     ST_UPDATED = 2'b01;
    localparam logic [1:0]     ST_FULL    = 2'b10;
    localparam logic [1:0]     ST_NOTFND  = 2'b11;
    localparam logic [IDX_W:0] SCAN_END   = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] ONE        = (IDX_W+1)'(1);

    state_t             r_state;
    logic [DEPTH-1:0]   r_valid;
    logic [KEY_W-1:0]   r_keys [DEPTH];
    logic [DEPTH-1:0]   r_ports;
    logic               r_op_add;
    logic [KEY_W-1:0]   r_key;
    logic               r_port;
    logic [IDX_W:0]     r_scan;
    logic               r_match;
    logic [IDX_W-1:0]   r_match_idx;
    logic               r_free;
    logic [IDX_W-1:0]   r_free_idx;
    logic [IDX_W-1:0]   r_wr_idx;
    logic               r_add_new;
    logic [1:0]         r_new_status;
    logic               r_busy;
    logic               r_done;
    logic [1:0]         r_status;
    logic               r_cam_we;
    logic [IDX_W-1:0]   r_cam_index;
    logic               r_cam_valid;
    logic               r_ram_we;
    logic [IDX_W-1:0]   r_ram_addr;
    logic [IDX_W:0]     r_count;
    logic [IDX_W-1:0]   w_scan_idx;

    assign w_scan_idx = r_scan[IDX_W-1:0];

    always_ff @(posedge clk50Mhz or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_ports      <= '0;
            for (int i = 0; i < DEPTH; i++) r_keys[i] <= '0;
            r_op_add     <= 1'b0;
            r_key        <= '0;
            r_port       <= 1'b0;
            r_scan       <= '0;
            r_match      <= 1'b0;
            r_match_idx  <= '0;
            r_free       <= 1'b0;
            r_free_idx   <= '0;
            r_wr_idx     <= '0;
            r_add_new    <= 1'b0;
            r_new_status <= ST_ADDED;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_status     <= ST_ADDED;
            r_cam_we     <= 1'b0;
            r_cam_index  <= '0;
            r_cam_valid  <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_count      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_wr_req || i_del_req) begin
                        r_op_add <= i_wr_req;
                        r_key    <= i_key;
                        r_port   <= i_port_in;
                        r_scan   <= '0;
                        r_match  <= 1'b0;
                        r_free   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (r_scan != SCAN_END) begin
                        // Only the first hit of each kind is kept, so ties go to the lowest index.
                        if (r_valid[w_scan_idx] && r_keys[w_scan_idx] == r_key && !r_match) begin
                            r_match     <= 1'b1;
                            r_match_idx <= w_scan_idx;
                        end
                        if (!r_valid[w_scan_idx] && !r_free) begin
                            r_free     <= 1'b1;
                            r_free_idx <= w_scan_idx;
                        end
                        r_scan <= r_scan + ONE;
                    end else if (r_op_add && r_match) begin
                        r_ram_we     <= 1'b1;
                        r_ram_addr   <= r_match_idx;
                        r_wr_idx     <= r_match_idx;
                        r_add_new    <= 1'b0;
                        r_new_status <= ST_UPDATED;
                        r_state      <= S_WRITE;
                    end else if (r_op_add && r_free) begin
                        r_cam_we     <= 1'b1;
                        r_cam_valid  <= 1'b1;
                        r_cam_index  <= r_free_idx;
                        r_ram_we     <= 1'b1;
                        r_ram_addr   <= r_free_idx;
                        r_wr_idx     <= r_free_idx;
                        r_add_new    <= 1'b1;
                        r_new_status <= ST_ADDED;
                        r_state      <= S_WRITE;
                    end else if (!r_op_add && r_match) begin
                        r_cam_we     <= 1'b1;
                        r_cam_valid  <= 1'b0;
                        r_cam_index  <= r_match_idx;
                        r_wr_idx     <= r_match_idx;
                        r_add_new    <= 1'b0;
                        r_new_status <= ST_UPDATED;
                        r_state      <= S_WRITE;
                    end else begin
                        r_status <= r_op_add ? ST_FULL : ST_NOTFND;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_WRITE: begin
                    r_cam_we    <= 1'b0;
                    r_ram_we    <= 1'b0;
                    r_cam_valid <= 1'b0;
                    if (r_op_add) begin
                        r_valid[r_wr_idx] <= 1'b1;
                        r_keys[r_wr_idx]  <= r_key;
                        r_ports[r_wr_idx] <= r_port;
                        if (r_add_new && r_count != SCAN_END) r_count <= r_count + ONE;
                    end else begin
                        r_valid[r_wr_idx] <= 1'b0;
                        if (r_count != '0) r_count <= r_count - ONE;
                    end
                    r_status <= r_new_status;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_status      = r_status;
    assign o_cam_we      = r_cam_we;
    assign o_cam_index   = r_cam_index;
    assign o_cam_key     = r_key;
    assign o_cam_valid   = r_cam_valid;
    assign o_ram_we      = r_ram_we;
    assign o_ram_addr    = r_ram_addr;
    assign o_ram_data    = r_port;
    assign o_entry_count = r_count;

endmodule

// File: tb/tb_route_table_writer.sv
// tb/tb_route_table_writer.sv - directed bench for route_table_writer
module tb_route_table_writer;

    logic       clk50Mhz = 1'b0;
    logic       reset;
    logic       i_wr_req, i_del_req, i_port_in;
    logic [3:0] i_key;
    logic       o_busy, o_done, o_cam_we, o_cam_valid, o_ram_we, o_ram_data;
    logic [1:0] o_status, o_cam_index, o_ram_addr;
    logic [3:0] o_cam_key;
    logic [2:0] o_entry_count;

    int checks = 0;
    int errors = 0;

    int         g_cam_cyc, g_cam_n, g_ram_cyc, g_ram_n, g_done_cyc, g_done_n;
    logic [1:0] g_cam_idx, g_ram_addr;
    logic [3:0] g_cam_key;
    logic       g_cam_valid, g_ram_data, g_rst_busy, g_rst_we;

    route_table_writer #(.DEPTH(4), .KEY_W(4), .IDX_W(2)) dut (
        .clk50Mhz(clk50Mhz), .reset(reset),
        .i_wr_req(i_wr_req), .i_del_req(i_del_req), .i_key(i_key), .i_port_in(i_port_in),
        .o_busy(o_busy), .o_done(o_done), .o_status(o_status),
        .o_cam_we(o_cam_we), .o_cam_index(o_cam_index), .o_cam_key(o_cam_key), .o_cam_valid(o_cam_valid),
        .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data),
        .o_entry_count(o_entry_count)
    );

    always #10 clk50Mhz = ~clk50Mhz;

    // Issues one request accepted at edge T, then watches 12 edges recording strobe/done cycles relative to T.
    task automatic do_cmd(input logic wr, input logic del, input logic [3:0] key, input logic port,
                          input int inj_cycle, input int rst_cycle);
        g_cam_cyc = 0; g_cam_n = 0; g_ram_cyc = 0; g_ram_n = 0; g_done_cyc = 0; g_done_n = 0;
        g_cam_idx = '0; g_cam_key = '0; g_cam_valid = 1'b0; g_ram_addr = '0; g_ram_data = 1'b0;
        g_rst_busy = 1'b0; g_rst_we = 1'b0;
        @(negedge clk50Mhz);
        i_wr_req = wr; i_del_req = del; i_key = key; i_port_in = port;
        @(posedge clk50Mhz); #1;
        i_wr_req = 1'b0; i_del_req = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk50Mhz); #1;
            i_wr_req = 1'b0;
            if (o_cam_we) begin
                g_cam_n++;
                if (g_cam_cyc == 0) begin
                    g_cam_cyc = k; g_cam_idx = o_cam_index; g_cam_key = o_cam_key; g_cam_valid = o_cam_valid;
                end
            end
            if (o_ram_we) begin
                g_ram_n++;
                if (g_ram_cyc == 0) begin
                    g_ram_cyc = k; g_ram_addr = o_ram_addr; g_ram_data = o_ram_data;
                end
            end
            if (o_done) begin
                g_done_n++;
                if (g_done_cyc == 0) g_done_cyc = k;
            end
            if (k == inj_cycle) begin
                i_wr_req = 1'b1; i_key = 4'hB; i_port_in = 1'b1;
            end
            if (k == rst_cycle) begin
                reset = 1'b0; #1;
                g_rst_busy = o_busy; g_rst_we = o_cam_we | o_ram_we;
                #5 reset = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; i_wr_req = 1'b0; i_del_req = 1'b0; i_key = '0; i_port_in = 1'b0;
        repeat (3) @(posedge clk50Mhz);
        @(negedge clk50Mhz); reset = 1'b1;
        @(posedge clk50Mhz); #1;
        checks++; if ({o_busy, o_done, o_cam_we, o_ram_we, o_cam_valid} !== 5'b0) begin errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {o_busy, o_done, o_cam_we, o_ram_we, o_cam_valid}); end
        checks++; if ({o_status, o_entry_count} !== 5'b0) begin errors++;
            $display("FAIL reset_status_count: got %b expected 00000", {o_status, o_entry_count}); end
        checks++; if ({o_cam_index, o_cam_key, o_ram_addr, o_ram_data} !== 9'b0) begin errors++;
            $display("FAIL reset_data: got %h expected 000", {o_cam_index, o_cam_key, o_ram_addr, o_ram_data}); end
    endtask

    task automatic test_add_first;
        do_cmd(1'b1, 1'b0, 4'h3, 1'b1, 0, 0);
        checks++; if (g_cam_cyc !== 5 || g_ram_cyc !== 5 || g_cam_n !== 1 || g_ram_n !== 1) begin errors++;
            $display("FAIL add1_strobes: got cam@%0d x%0d ram@%0d x%0d expected cam@5 x1 ram@5 x1", g_cam_cyc, g_cam_n, g_ram_cyc, g_ram_n); end
        checks++; if ({g_cam_idx, g_cam_key, g_cam_valid, g_ram_addr, g_ram_data} !== {2'd0, 4'h3, 1'b1, 2'd0, 1'b1}) begin errors++;
            $display("FAIL add1_fields: got idx %0d key %h v %b addr %0d data %b expected 0 3 1 0 1", g_cam_idx, g_cam_key, g_cam_valid, g_ram_addr, g_ram_data); end
        checks++; if (g_done_cyc !== 6 || g_done_n !== 1 || o_status !== 2'b00 || o_entry_count !== 3'd1) begin errors++;
            $display("FAIL add1_done: got done@%0d x%0d status %b count %0d expected 6 x1 00 1", g_done_cyc, g_done_n, o_status, o_entry_count); end
    endtask

    task automatic test_update;
        do_cmd(1'b1, 1'b0, 4'h3, 1'b0, 0, 0);
        checks++; if (g_cam_n !== 0 || g_ram_cyc !== 5 || g_ram_n !== 1 || g_ram_addr !== 2'd0 || g_ram_data !== 1'b0) begin errors++;
            $display("FAIL update_strobes: got cam x%0d ram@%0d x%0d addr %0d data %b expected x0 5 x1 0 0", g_cam_n, g_ram_cyc, g_ram_n, g_ram_addr, g_ram_data); end
        checks++; if (g_done_cyc !== 6 || o_status !== 2'b01 || o_entry_count !== 3'd1) begin errors++;
            $display("FAIL update_done: got done@%0d status %b count %0d expected 6 01 1", g_done_cyc, o_status, o_entry_count); end
    endtask

    task automatic test_fill;
        logic [3:0] keys [3];
        keys[0] = 4'h1; keys[1] = 4'h5; keys[2] = 4'h7;
        for (int i = 0; i < 3; i++) begin
            do_cmd(1'b1, 1'b0, keys[i], 1'b1, 0, 0);
            checks++; if (g_cam_cyc !== 5 || g_cam_idx !== 2'(i + 1) || g_cam_key !== keys[i] || o_entry_count !== 3'(i + 2)) begin errors++;
                $display("FAIL fill_%0d: got cam@%0d idx %0d key %h count %0d expected 5 %0d %h %0d", i, g_cam_cyc, g_cam_idx, g_cam_key, o_entry_count, i + 1, keys[i], i + 2); end
        end
        do_cmd(1'b1, 1'b0, 4'h9, 1'b0, 0, 0);
        checks++; if (g_cam_n !== 0 || g_ram_n !== 0 || g_done_cyc !== 5 || o_status !== 2'b10 || o_entry_count !== 3'd4) begin errors++;
            $display("FAIL full: got cam x%0d ram x%0d done@%0d status %b count %0d expected 0 0 5 10 4", g_cam_n, g_ram_n, g_done_cyc, o_status, o_entry_count); end
    endtask

    task automatic test_delete_reuse;
        do_cmd(1'b0, 1'b1, 4'h5, 1'b0, 0, 0);
        checks++; if (g_cam_cyc !== 5 || g_cam_idx !== 2'd2 || g_cam_valid !== 1'b0 || g_ram_n !== 0) begin errors++;
            $display("FAIL del_strobes: got cam@%0d idx %0d v %b ram x%0d expected 5 2 0 0", g_cam_cyc, g_cam_idx, g_cam_valid, g_ram_n); end
        checks++; if (g_done_cyc !== 6 || o_status !== 2'b01 || o_entry_count !== 3'd3) begin errors++;
            $display("FAIL del_done: got done@%0d status %b count %0d expected 6 01 3", g_done_cyc, o_status, o_entry_count); end
        do_cmd(1'b1, 1'b0, 4'h9, 1'b1, 0, 0);
        checks++; if (g_cam_idx !== 2'd2 || g_cam_valid !== 1'b1 || g_ram_addr !== 2'd2 || o_status !== 2'b00 || o_entry_count !== 3'd4) begin errors++;
            $display("FAIL reuse: got idx %0d v %b addr %0d status %b count %0d expected 2 1 2 00 4", g_cam_idx, g_cam_valid, g_ram_addr, o_status, o_entry_count); end
    endtask

    task automatic test_not_found_busy;
        do_cmd(1'b0, 1'b1, 4'hA, 1'b0, 0, 0);
        checks++; if (g_cam_n !== 0 || g_ram_n !== 0 || g_done_cyc !== 5 || o_status !== 2'b11 || o_entry_count !== 3'd4) begin errors++;
            $display("FAIL not_found: got cam x%0d ram x%0d done@%0d status %b count %0d expected 0 0 5 11 4", g_cam_n, g_ram_n, g_done_cyc, o_status, o_entry_count); end
        do_cmd(1'b1, 1'b0, 4'h3, 1'b1, 2, 0);
        checks++; if (g_done_n !== 1 || g_done_cyc !== 6 || g_ram_cyc !== 5 || o_status !== 2'b01 || o_busy !== 1'b0) begin errors++;
            $display("FAIL busy_drop: got done x%0d @%0d ram@%0d status %b busy %b expected x1 6 5 01 0", g_done_n, g_done_cyc, g_ram_cyc, o_status, o_busy); end
    endtask

    task automatic test_simultaneous;
        do_cmd(1'b1, 1'b1, 4'h3, 1'b0, 0, 0);
        checks++; if (g_cam_n !== 0 || g_ram_cyc !== 5 || g_ram_addr !== 2'd0 || g_ram_data !== 1'b0 || o_status !== 2'b01 || o_entry_count !== 3'd4) begin errors++;
            $display("FAIL wr_wins: got cam x%0d ram@%0d addr %0d data %b status %b count %0d expected 0 5 0 0 01 4", g_cam_n, g_ram_cyc, g_ram_addr, g_ram_data, o_status, o_entry_count); end
    endtask

    task automatic test_reset_mid;
        do_cmd(1'b0, 1'b1, 4'h3, 1'b0, 0, 3);
        checks++; if (g_rst_busy !== 1'b0 || g_rst_we !== 1'b0 || g_cam_n !== 0 || g_ram_n !== 0 || g_done_n !== 0) begin errors++;
            $display("FAIL reset_mid: got busy %b we %b cam x%0d ram x%0d done x%0d expected 0 0 0 0 0", g_rst_busy, g_rst_we, g_cam_n, g_ram_n, g_done_n); end
        checks++; if (o_entry_count !== 3'd0 || o_busy !== 1'b0 || o_status !== 2'b00) begin errors++;
            $display("FAIL reset_mid_state: got count %0d busy %b status %b expected 0 0 00", o_entry_count, o_busy, o_status); end
        do_cmd(1'b1, 1'b0, 4'h7, 1'b0, 0, 0);
        checks++; if (g_cam_cyc !== 5 || g_cam_idx !== 2'd0 || o_status !== 2'b00 || o_entry_count !== 3'd1) begin errors++;
            $display("FAIL after_reset_add: got cam@%0d idx %0d status %b count %0d expected 5 0 00 1", g_cam_cyc, g_cam_idx, o_status, o_entry_count); end
    endtask

    initial begin
        test_reset;
        test_add_first;
        test_update;
        test_fill;
        test_delete_reuse;
        test_not_found_busy;
        test_simultaneous;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/route_table_writer.md
# route_table_writer

Programming-side counterpart of the router's address lookup path. It accepts add/delete commands for {destination address, output port} pairs and writes the 4-entry address CAM and the port RAM that the forwarding path reads. It keeps a shadow copy of the table so it can detect duplicates, a full table and missing entries. It sits between the debounced pushbutton/switch inputs and the write ports of the CAM and port RAM.

## Interface
- DEPTH, 4, number of table entries; power of two
- KEY_W, 4, address (key) width
- IDX_W, 2, index width, log2(DEPTH)
- clk50Mhz  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wr_req  in  1  single-cycle pulse: add or update entry key→port_in
- del_req  in  1  single-cycle pulse: delete entry key
- key  in  KEY_W  destination address; sampled on request acceptance
- port_in  in  1  output port; sampled on request acceptance
- busy  out  1  command in progress
- done  out  1  single-cycle completion pulse
- status  out  2  result of last command: 00 added, 01 updated/deleted, 10 full, 11 not found
- cam_we  out  1  CAM write strobe
- cam_index  out  IDX_W  CAM entry being written
- cam_key  out  KEY_W  key written to the CAM
- cam_valid  out  1  valid bit written; 0 means delete
- ram_we  out  1  port RAM write strobe
- ram_addr  out  IDX_W  port RAM address
- ram_data  out  1  port value written
- entry_count  out  IDX_W+1  number of valid entries, 0..DEPTH

## Operation
- Shadow table: DEPTH entries of {valid, key, port}. All valid bits are cleared on reset.
- FSM states: IDLE, SEARCH, WRITE, DONE.
- IDLE
  - Accept a request only in IDLE. Requests arriving in any other state are dropped.
  - If wr_req and del_req are asserted together, wr_req wins.
  - On acceptance, latch op, key and port_in; clear scan_idx; go to SEARCH.
- SEARCH
  - Compare one entry per cycle, at scan_idx = 0..DEPTH-1.
  - Record the first valid entry whose key equals the latched key (match).
  - Record the lowest-index invalid entry (free).
  - After entry DEPTH-1, decide the next step:
    - add, match: WRITE with ram_we only at the match index; status 01.
    - add, no match, free slot exists: WRITE with cam_we=1, cam_valid=1 and ram_we=1 at the free index; status 00; entry_count+1.
    - add, no match, no free slot: DONE, status 10; no write.
    - delete, match: WRITE with cam_we=1 and cam_valid=0 at the match index; status 01; entry_count-1.
    - delete, no match: DONE, status 11; no write.
- WRITE
  - The strobes are high for exactly one cycle.
  - The shadow table and entry_count update on the same edge the strobes deassert.
  - Go to DONE.
- DONE
  - done=1 for one cycle; status takes its new value.
  - Return to IDLE.
- Outputs when not writing: cam_key=latched key and ram_data=latched port in all states. cam_index/ram_addr are don't-care when their strobe is low.
- entry_count never exceeds DEPTH and never goes below 0.

## Timing
- Reset values: state IDLE; busy, done, cam_we, ram_we and cam_valid 0; status 00; entry_count 0; cam_index, cam_key, ram_addr and ram_data 0.
- Request accepted at edge T:
  - busy=1 from T through the DONE cycle.
  - SEARCH occupies cycles T+1..T+DEPTH.
  - Write path: WRITE at T+DEPTH+1 (strobes high), DONE at T+DEPTH+2. With DEPTH=4: strobes at T+5, done at T+6.
  - No-write path (full or not found): DONE at T+DEPTH+1.
  - busy falls on the edge that leaves DONE. A new request is accepted on the following edge at the earliest.
- Reset asserted mid-command:
  - Return immediately to IDLE and drop any pending write; strobes go low asynchronously.
  - The shadow table is cleared; the CAM is cleared by the same reset.

## Test plan
- Reset, then add key 0x3 port 1 → cam_we and ram_we at T+5 with index 0, key 0x3, valid 1, data 1; done at T+6; status 00; entry_count 1.
- Add 0x3 port 0 again → only ram_we at T+5, addr 0, data 0; status 01; entry_count stays 1.
- Add 0x1, 0x5, 0x7, then 0x9 → first three land at indices 1, 2, 3; 0x9 gets no strobes, done at T+5, status 10, entry_count 4.
- Delete 0x5, then add 0x9 → delete writes index 2 with valid 0 (count 3); the add reuses index 2 (count 4).
- Delete 0xA on a table without it → no strobes, status 11, done at T+5. Assert wr_req while busy → ignored, with no second done pulse.
- Assert wr_req and del_req together for key 0x3 → treated as an add. Drop reset at T+3 → no strobes, entry_count 0, busy 0.
